// File: rtl/mem_bus_pkg.sv
// +----------------------------------------------------------------------------+
// | mem_bus_pkg                                                                |
// | Shared constants and encodings for the memory-bus address demultiplexer.   |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

package mem_bus_pkg;

    localparam logic [31:0] ERR_RDATA = 32'hDEAD_BEEF;

    typedef enum logic [1:0] {
        ERR_NONE     = 2'd0,
        ERR_UNMAPPED = 2'd1,
        ERR_TIMEOUT  = 2'd2
    } err_code_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_ERR  = 2'd2
    } state_e;

endpackage

`default_nettype wire

// File: rtl/mem_addr_match.sv
// +----------------------------------------------------------------------------+
// | mem_addr_match                                                             |
// | Masked base-address comparator: hit when all masked address bits match.    |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module mem_addr_match (
    input  logic [31:0] base,
    input  logic [31:0] mask,
    input  logic [31:0] addr,
    output logic        hit
);

    assign hit = (((addr ^ base) & mask) == 32'd0);

endmodule

`default_nettype wire

// File: rtl/mem_addr_demux.sv
// +----------------------------------------------------------------------------+
// | mem_addr_demux                                                             |
// | Routes one upstream memory request to the lowest-index matching slave,     |
// | terminating unmapped or timed-out requests with an error response.         |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module mem_addr_demux
    import mem_bus_pkg::*;
#(
    parameter int unsigned                N_SLAVES   = 4,
    parameter logic [N_SLAVES*32-1:0]     BASE_ADDRS = '0,
    parameter logic [N_SLAVES*32-1:0]     ADDR_MASKS = '0,
    parameter int unsigned                TIMEOUT    = 256
) (
    input  logic                     clk,
    input  logic                     resetn,
    input  logic                     s_mem_valid,
    output logic                     s_mem_ready,
    input  logic [31:0]              s_mem_addr,
    input  logic [31:0]              s_mem_wdata,
    input  logic [3:0]               s_mem_wstrb,
    output logic [31:0]              s_mem_rdata,
    output logic [N_SLAVES-1:0]      m_mem_valid,
    input  logic [N_SLAVES-1:0]      m_mem_ready,
    output logic [31:0]              m_mem_addr,
    output logic [31:0]              m_mem_wdata,
    output logic [3:0]               m_mem_wstrb,
    input  logic [N_SLAVES*32-1:0]   m_mem_rdata,
    output logic                     err_pulse,
    output logic [1:0]               err_code,
    output logic [31:0]              err_addr
);

    localparam logic [15:0] c_cnt_last = 16'(TIMEOUT - 1);

    state_e                r_state;
    logic [N_SLAVES-1:0]   r_sel;
    logic [15:0]           r_cnt;
    logic [31:0]           r_req_addr;
    logic                  r_err_pulse;
    err_code_e             r_err_code;
    logic [31:0]           r_err_addr;

    logic [N_SLAVES-1:0]   w_hit;
    logic [N_SLAVES-1:0]   w_first;
    logic                  w_found;
    logic                  w_sel_ready;
    logic [31:0]           w_sel_rdata;

    generate
        for (genvar k = 0; k < N_SLAVES; k++) begin : g_match
            mem_addr_match u_match (
                .base (BASE_ADDRS[32*k +: 32]),
                .mask (ADDR_MASKS[32*k +: 32]),
                .addr (s_mem_addr),
                .hit  (w_hit[k])
            );
        end
    endgenerate

    // Lowest index wins when several windows overlap.
    always_comb begin
        w_first = '0;
        w_found = 1'b0;
        for (int k = 0; k < N_SLAVES; k++) begin
            if (w_hit[k] && !w_found) begin
                w_first[k] = 1'b1;
                w_found    = 1'b1;
            end
        end
    end

    always_comb begin
        w_sel_rdata = '0;
        for (int k = 0; k < N_SLAVES; k++) begin
            if (r_sel[k]) begin
                w_sel_rdata = w_sel_rdata | m_mem_rdata[32*k +: 32];
            end
        end
    end

    assign w_sel_ready = |(r_sel & m_mem_ready);

    // Handshake outputs are also gated by resetn so an aborted transfer never completes.
    always_comb begin
        m_mem_valid = '0;
        s_mem_ready = 1'b0;
        s_mem_rdata = '0;
        case (r_state)
            ST_BUSY: begin
                m_mem_valid = resetn ? (r_sel & {N_SLAVES{s_mem_valid}}) : '0;
                s_mem_ready = resetn & w_sel_ready;
                s_mem_rdata = w_sel_rdata;
            end
            ST_ERR: begin
                s_mem_ready = resetn;
                s_mem_rdata = ERR_RDATA;
            end
            default: ;
        endcase
    end

    assign m_mem_addr  = s_mem_addr;
    assign m_mem_wdata = s_mem_wdata;
    assign m_mem_wstrb = s_mem_wstrb;
    assign err_pulse   = r_err_pulse;
    assign err_code    = r_err_code;
    assign err_addr    = r_err_addr;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_state     <= ST_IDLE;
            r_sel       <= '0;
            r_cnt       <= '0;
            r_req_addr  <= '0;
            r_err_pulse <= 1'b0;
            r_err_code  <= ERR_NONE;
            r_err_addr  <= '0;
        end else begin
            r_err_pulse <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (s_mem_valid) begin
                        r_req_addr <= s_mem_addr;
                        if (w_found) begin
                            r_sel   <= w_first;
                            r_cnt   <= '0;
                            r_state <= ST_BUSY;
                        end else begin
                            r_sel       <= '0;
                            r_state     <= ST_ERR;
                            r_err_pulse <= 1'b1;
                            r_err_code  <= ERR_UNMAPPED;
                            r_err_addr  <= s_mem_addr;
                        end
                    end
                end
                ST_BUSY: begin
                    // Ready is checked before the terminal count so it wins a tie.
                    if (!s_mem_valid || w_sel_ready) begin
                        r_sel   <= '0;
                        r_state <= ST_IDLE;
                    end else if (r_cnt == c_cnt_last) begin
                        r_sel       <= '0;
                        r_state     <= ST_ERR;
                        r_err_pulse <= 1'b1;
                        r_err_code  <= ERR_TIMEOUT;
                        r_err_addr  <= r_req_addr;
                    end else begin
                        r_cnt <= r_cnt + 16'd1;
                    end
                end
                ST_ERR: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_sel   <= '0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_mem_addr_demux.sv
// +----------------------------------------------------------------------------+
// | tb_mem_addr_demux                                                          |
// | Directed self-checking bench for mem_addr_demux.                           |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_mem_addr_demux;

    localparam int unsigned N = 4;

    logic               clk = 1'b0;
    logic               resetn;
    logic [31:0]        s_addr;
    logic [31:0]        s_wdata;
    logic [3:0]         s_wstrb;
    logic [N*32-1:0]    m_rdata;

    logic               s_valid_a, s_ready_a, err_pulse_a;
    logic [31:0]        s_rdata_a, m_addr_a, m_wdata_a, err_addr_a;
    logic [3:0]         m_wstrb_a;
    logic [N-1:0]       m_valid_a, m_ready_a;
    logic [1:0]         err_code_a;

    logic               s_valid_b, s_ready_b, err_pulse_b;
    logic [31:0]        s_rdata_b, m_addr_b, m_wdata_b, err_addr_b;
    logic [3:0]         m_wstrb_b;
    logic [N-1:0]       m_valid_b, m_ready_b;
    logic [1:0]         err_code_b;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    mem_addr_demux #(
        .N_SLAVES   (N),
        .BASE_ADDRS ({32'h0000_3000, 32'h0000_2000, 32'h0000_1000, 32'h0000_0000}),
        .ADDR_MASKS ({4{32'hFFFF_F000}}),
        .TIMEOUT    (8)
    ) dut_a (
        .clk         (clk),
        .resetn      (resetn),
        .s_mem_valid (s_valid_a),
        .s_mem_ready (s_ready_a),
        .s_mem_addr  (s_addr),
        .s_mem_wdata (s_wdata),
        .s_mem_wstrb (s_wstrb),
        .s_mem_rdata (s_rdata_a),
        .m_mem_valid (m_valid_a),
        .m_mem_ready (m_ready_a),
        .m_mem_addr  (m_addr_a),
        .m_mem_wdata (m_wdata_a),
        .m_mem_wstrb (m_wstrb_a),
        .m_mem_rdata (m_rdata),
        .err_pulse   (err_pulse_a),
        .err_code    (err_code_a),
        .err_addr    (err_addr_a)
    );

    // Slave 3 window covers 0x0000-0xFFFF and so overlaps slave 0.
    mem_addr_demux #(
        .N_SLAVES   (N),
        .BASE_ADDRS ({32'h0000_0000, 32'h0000_2000, 32'h0000_1000, 32'h0000_0000}),
        .ADDR_MASKS ({32'hFFFF_0000, 32'hFFFF_F000, 32'hFFFF_F000, 32'hFFFF_F000}),
        .TIMEOUT    (256)
    ) dut_b (
        .clk         (clk),
        .resetn      (resetn),
        .s_mem_valid (s_valid_b),
        .s_mem_ready (s_ready_b),
        .s_mem_addr  (s_addr),
        .s_mem_wdata (s_wdata),
        .s_mem_wstrb (s_wstrb),
        .s_mem_rdata (s_rdata_b),
        .m_mem_valid (m_valid_b),
        .m_mem_ready (m_ready_b),
        .m_mem_addr  (m_addr_b),
        .m_mem_wdata (m_wdata_b),
        .m_mem_wstrb (m_wstrb_b),
        .m_mem_rdata (m_rdata),
        .err_pulse   (err_pulse_b),
        .err_code    (err_code_b),
        .err_addr    (err_addr_b)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        resetn    = 1'b0;
        s_valid_a = 1'b0;
        s_valid_b = 1'b0;
        m_ready_a = '0;
        m_ready_b = '0;
        s_addr    = '0;
        s_wdata   = '0;
        s_wstrb   = '0;
        m_rdata   = {32'h3333_3333, 32'h2222_2222, 32'h1111_1111, 32'hAAAA_0000};

        tick();
        tick();
        resetn = 1'b1;
        #1;
        chk("rst_m_valid",  32'(m_valid_a), 32'h0);
        chk("rst_s_ready",  32'(s_ready_a), 32'h0);
        chk("rst_s_rdata",  s_rdata_a,      32'h0);
        chk("rst_err_pulse",32'(err_pulse_a), 32'h0);
        chk("rst_err_code", 32'(err_code_a), 32'h0);
        chk("rst_err_addr", err_addr_a,     32'h0);

        // Read of 0x2004, slave 2 answers three cycles after the request.
        s_valid_a = 1'b1; s_addr = 32'h0000_2004; s_wstrb = 4'h0; s_wdata = 32'h5A5A_5A5A;
        #1;
        chk("rd_idle_m_valid", 32'(m_valid_a), 32'h0);
        chk("rd_idle_ready",   32'(s_ready_a), 32'h0);
        chk("rd_pass_addr",    m_addr_a,       32'h0000_2004);
        chk("rd_pass_wdata",   m_wdata_a,      32'h5A5A_5A5A);
        tick();
        chk("rd_busy1_m_valid", 32'(m_valid_a), 32'h4);
        chk("rd_busy1_ready",   32'(s_ready_a), 32'h0);
        tick();
        chk("rd_busy2_m_valid", 32'(m_valid_a), 32'h4);
        tick();
        m_ready_a = 4'b0100;
        #1;
        chk("rd_done_ready", 32'(s_ready_a), 32'h1);
        chk("rd_done_rdata", s_rdata_a,      32'h2222_2222);
        tick();
        s_valid_a = 1'b0; m_ready_a = '0;
        #1;
        chk("rd_after_m_valid", 32'(m_valid_a), 32'h0);
        chk("rd_after_ready",   32'(s_ready_a), 32'h0);
        chk("rd_after_pulse",   32'(err_pulse_a), 32'h0);

        // Unmapped write to 0x9000.
        s_valid_a = 1'b1; s_addr = 32'h0000_9000; s_wstrb = 4'hF;
        #1;
        chk("um_pass_wstrb", 32'(m_wstrb_a), 32'hF);
        tick();
        chk("um_ready",   32'(s_ready_a),   32'h1);
        chk("um_rdata",   s_rdata_a,        32'hDEAD_BEEF);
        chk("um_m_valid", 32'(m_valid_a),   32'h0);
        chk("um_pulse",   32'(err_pulse_a), 32'h1);
        chk("um_code",    32'(err_code_a),  32'h1);
        chk("um_addr",    err_addr_a,       32'h0000_9000);
        tick();
        s_valid_a = 1'b0;
        #1;
        chk("um_after_pulse", 32'(err_pulse_a), 32'h0);
        chk("um_after_ready", 32'(s_ready_a),   32'h0);
        chk("um_after_code",  32'(err_code_a),  32'h1);

        // Slave 1 never ready: eight BUSY cycles then timeout.
        s_valid_a = 1'b1; s_addr = 32'h0000_1010; s_wstrb = 4'h0;
        tick();
        chk("to_busy1_m_valid", 32'(m_valid_a), 32'h2);
        for (int i = 2; i <= 8; i++) tick();
        chk("to_busy8_m_valid", 32'(m_valid_a), 32'h2);
        chk("to_busy8_ready",   32'(s_ready_a), 32'h0);
        tick();
        chk("to_err_m_valid", 32'(m_valid_a),   32'h0);
        chk("to_err_ready",   32'(s_ready_a),   32'h1);
        chk("to_err_pulse",   32'(err_pulse_a), 32'h1);
        chk("to_err_code",    32'(err_code_a),  32'h2);
        chk("to_err_addr",    err_addr_a,       32'h0000_1010);
        chk("to_err_rdata",   s_rdata_a,        32'hDEAD_BEEF);
        tick();
        s_valid_a = 1'b0;

        // Ready arrives on the terminal count: normal completion wins.
        s_valid_a = 1'b1; s_addr = 32'h0000_1020;
        tick();
        for (int i = 2; i <= 8; i++) tick();
        m_ready_a = 4'b0010;
        #1;
        chk("tc_ready", 32'(s_ready_a), 32'h1);
        chk("tc_rdata", s_rdata_a,      32'h1111_1111);
        tick();
        s_valid_a = 1'b0; m_ready_a = '0;
        #1;
        chk("tc_after_pulse",   32'(err_pulse_a), 32'h0);
        chk("tc_after_ready",   32'(s_ready_a),   32'h0);
        chk("tc_after_m_valid", 32'(m_valid_a),   32'h0);
        chk("tc_after_code",    32'(err_code_a),  32'h2);

        // Upstream valid withdrawn mid-BUSY: quiet return to IDLE.
        s_valid_a = 1'b1; s_addr = 32'h0000_0040;
        tick();
        chk("wd_busy_m_valid", 32'(m_valid_a), 32'h1);
        s_valid_a = 1'b0;
        #1;
        chk("wd_drop_m_valid", 32'(m_valid_a), 32'h0);
        tick();
        chk("wd_after_pulse", 32'(err_pulse_a), 32'h0);
        chk("wd_after_ready", 32'(s_ready_a),   32'h0);
        s_valid_a = 1'b1; s_addr = 32'h0000_3000;
        #1;
        chk("wd_idle_m_valid", 32'(m_valid_a), 32'h0);
        tick();
        chk("wd_next_m_valid", 32'(m_valid_a), 32'h8);

        // Reset pulse mid-BUSY while the slave is ready.
        resetn = 1'b0; m_ready_a = 4'b1000;
        #1;
        chk("rb_no_ready", 32'(s_ready_a), 32'h0);
        tick();
        resetn = 1'b1;
        #1;
        chk("rb_m_valid",  32'(m_valid_a),   32'h0);
        chk("rb_ready",    32'(s_ready_a),   32'h0);
        chk("rb_rdata",    s_rdata_a,        32'h0);
        chk("rb_code",     32'(err_code_a),  32'h0);
        chk("rb_err_addr", err_addr_a,       32'h0);
        chk("rb_pulse",    32'(err_pulse_a), 32'h0);
        s_valid_a = 1'b0; m_ready_a = '0;
        tick();

        // Overlapping windows: slave 0 selected, address change does not reroute.
        s_valid_b = 1'b1; s_addr = 32'h0000_0004;
        tick();
        chk("ov_sel", 32'(m_valid_b), 32'h1);
        s_addr = 32'h0000_3004;
        tick();
        chk("ov_hold", 32'(m_valid_b), 32'h1);
        m_ready_b = 4'b1001;
        #1;
        chk("ov_ready", 32'(s_ready_b), 32'h1);
        chk("ov_rdata", s_rdata_b,      32'hAAAA_0000);
        tick();
        s_valid_b = 1'b0; m_ready_b = '0;
        #1;
        chk("ov_after_m_valid", 32'(m_valid_b), 32'h0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
